level_mem_n: RTL and testbench

//  Parametrised level memory: holds a game/sequence level 0..LEVELS and presents it as thermometer + binary.

---
 rtl/level_mem_n_pkg.sv | 32 +++
 rtl/level_mem_n_edge_rpt.sv | 29 ++
 rtl/level_mem_n.sv | 137 +++++++++++++
 tb/tb_level_mem_n.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/level_mem_n_pkg.sv
// Shared constants, step-kind enum and thermometer helper for the level memory.
package level_mem_n_pkg;

  // Default highest level.
  localparam int LEVEL_MAX = 8;

  // Widest thermometer the helper can build. LEVELS must not exceed this.
  localparam int THERM_MAX = 256;

  // Which way the level moves in a cycle after arbitration.
  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DOWN = 2'd2
  } step_e;

  // Binary width that holds 0..levels.
  function automatic int level_w(input int levels);
    return $clog2(levels + 1);
  endfunction

  // Thermometer code: bit i is set iff level > i. Callers truncate to LEVELS bits.
  function automatic logic [THERM_MAX-1:0] therm(input int unsigned level);
    logic [THERM_MAX-1:0] t;
    t = '0;
    for (int unsigned i = 0; i < THERM_MAX; i++) begin
      t[i] = (level > i);
    end
    return t;
  endfunction

endpackage

// File: rtl/level_mem_n_edge_rpt.sv
// Per-direction button front end: rising-edge detect plus a qualified repeat tick.
// The repeat counter itself is shared and lives in the top; this block only
// turns the shared tick into a step event for its own direction.
module level_mem_n_edge_rpt
  import level_mem_n_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic tick,
  output logic rise,
  output logic ev
);

  logic btn_q;

  // Previous button sample; cleared by reset so a button held through reset counts as a fresh edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_q <= 1'b0;
    end else begin
      btn_q <= btn;
    end
  end

  assign rise = btn & ~btn_q;
  assign ev   = rise | (btn & tick);

endmodule

// File: rtl/level_mem_n.sv
// Parametrised level memory: holds a level 0..LEVELS, steps it up/down from
// edge-detected, auto-repeating buttons, and presents it as thermometer + binary
// with max/zero flags and a one-cycle limit pulse. All outputs are registered.
module level_mem_n
  import level_mem_n_pkg::*;
#(
  parameter int LEVELS = LEVEL_MAX,
  parameter int W      = level_w(LEVELS),
  parameter int REPEAT = 4,
  parameter int WRAP   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              setzero,
  input  logic              on,
  input  logic              up,
  input  logic              down,
  output logic [LEVELS-1:0] lv,
  output logic [W-1:0]      lv_bin,
  output logic              at_max,
  output logic              at_zero,
  output logic              limit
);

  // LEVELS is expected in 2..THERM_MAX; W is derived and should not be overridden.

  localparam int CW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [CW-1:0] RPT_LAST  = CW'((REPEAT > 0) ? REPEAT - 1 : 0);
  localparam logic [CW-1:0] RPT_ONE   = CW'(1);
  localparam logic [W-1:0]  LEVEL_TOP = W'(LEVELS);
  localparam logic [W-1:0]  LVL_ZERO  = W'(0);
  localparam logic [W-1:0]  LVL_ONE   = W'(1);

  logic [W-1:0]  level;
  logic [W-1:0]  level_nxt;
  logic          limit_nxt;
  logic [CW-1:0] rpt_cnt;
  logic          held_alone;
  logic          any_rise;
  logic          rpt_tick;
  logic          up_rise, dn_rise;
  logic          up_ev, dn_ev;
  step_e         step;

  // Saturating / wrapping increment: returns {limit, new_level}.
  function automatic logic [W:0] step_up(input logic [W-1:0] cur);
    if (cur == LEVEL_TOP) begin
      return {1'b1, (WRAP != 0) ? LVL_ZERO : cur};
    end
    return {1'b0, cur + LVL_ONE};
  endfunction

  // Saturating / wrapping decrement: returns {limit, new_level}.
  function automatic logic [W:0] step_down(input logic [W-1:0] cur);
    if (cur == LVL_ZERO) begin
      return {1'b1, (WRAP != 0) ? LEVEL_TOP : cur};
    end
    return {1'b0, cur - LVL_ONE};
  endfunction

  // Repeat is only meaningful while exactly one button is held and no new edge arrived.
  assign held_alone = up ^ down;
  assign any_rise   = up_rise | dn_rise;
  assign rpt_tick   = (REPEAT > 0) && held_alone && !any_rise && (rpt_cnt == RPT_LAST);

  level_mem_n_edge_rpt u_up (
    .clk   (clk),
    .reset (reset),
    .btn   (up),
    .tick  (rpt_tick),
    .rise  (up_rise),
    .ev    (up_ev)
  );

  level_mem_n_edge_rpt u_down (
    .clk   (clk),
    .reset (reset),
    .btn   (down),
    .tick  (rpt_tick),
    .rise  (dn_rise),
    .ev    (dn_ev)
  );

  // Shared repeat counter: restarts on any edge, release, both-held, setzero or after each tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rpt_cnt <= '0;
    end else if (setzero || any_rise || !held_alone || rpt_tick || (REPEAT == 0)) begin
      rpt_cnt <= '0;
    end else begin
      rpt_cnt <= rpt_cnt + RPT_ONE;
    end
  end

  // Next level and limit: setzero beats power-on, power-on at level 0 beats stepping.
  always_comb begin
    level_nxt = level;
    limit_nxt = 1'b0;
    step      = STEP_NONE;
    if (up_ev && !dn_ev) begin
      step = STEP_UP;
    end else if (dn_ev && !up_ev) begin
      step = STEP_DOWN;
    end
    if (setzero) begin
      level_nxt = LVL_ZERO;
    end else if (on && (level == LVL_ZERO)) begin
      level_nxt = LVL_ONE;
    end else begin
      case (step)
        STEP_UP:   {limit_nxt, level_nxt} = step_up(level);
        STEP_DOWN: {limit_nxt, level_nxt} = step_down(level);
        default:   level_nxt = level;
      endcase
    end
  end

  // Level register and registered decode, all updated from the same next-level value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level   <= LVL_ZERO;
      lv      <= '0;
      at_max  <= 1'b0;
      at_zero <= 1'b1;
      limit   <= 1'b0;
    end else begin
      level   <= level_nxt;
      lv      <= LEVELS'(therm(32'(level_nxt)));
      at_max  <= (level_nxt == LEVEL_TOP);
      at_zero <= (level_nxt == LVL_ZERO);
      limit   <= limit_nxt;
    end
  end

  assign lv_bin = level;

endmodule

// File: tb/tb_level_mem_n.sv
// Directed bench for level_mem_n: one saturating instance driven from a vector
// table, one wrapping instance driven by a short hand sequence, plus an
// asynchronous-reset-mid-hold sequence.
module tb_level_mem_n;

  logic       clk = 1'b0;
  logic       reset;
  logic       setzero, on, up, down;
  logic [7:0] lv;
  logic [3:0] lv_bin;
  logic       at_max, at_zero, limit;
  logic       w_setzero, w_on, w_up, w_down;
  logic [7:0] w_lv;
  logic [3:0] w_lv_bin;
  logic       w_at_max, w_at_zero, w_limit;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic sz;
    logic o;
    logic u;
    logic d;
    int   eb;
    logic el;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  level_mem_n #(.LEVELS(8), .REPEAT(4), .WRAP(0)) dut (
    .clk(clk), .reset(reset), .setzero(setzero), .on(on), .up(up), .down(down),
    .lv(lv), .lv_bin(lv_bin), .at_max(at_max), .at_zero(at_zero), .limit(limit)
  );

  level_mem_n #(.LEVELS(8), .REPEAT(4), .WRAP(1)) dut_w (
    .clk(clk), .reset(reset), .setzero(w_setzero), .on(w_on), .up(w_up), .down(w_down),
    .lv(w_lv), .lv_bin(w_lv_bin), .at_max(w_at_max), .at_zero(w_at_zero), .limit(w_limit)
  );

  function automatic logic [7:0] th8(input int b);
    logic [7:0] t;
    for (int i = 0; i < 8; i++) t[i] = (b > i);
    return t;
  endfunction

  task automatic chk(input string nm, input logic [14:0] act, input int eb, input logic el);
    logic [14:0] exp;
    exp = {th8(eb), 4'(eb), (eb == 8), (eb == 0), el};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got lv=%b bin=%0d max=%b zero=%b lim=%b, want lv=%b bin=%0d max=%b zero=%b lim=%b",
               nm, act[14:7], act[6:3], act[2], act[1], act[0],
               exp[14:7], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic apply(input bit wsel, input logic sz, input logic o, input logic u, input logic d,
                       input int eb, input logic el, input string nm);
    if (wsel) {w_setzero, w_on, w_up, w_down} = {sz, o, u, d};
    else      {setzero, on, up, down}         = {sz, o, u, d};
    @(posedge clk);
    #1;
    if (wsel) chk(nm, {w_lv, w_lv_bin, w_at_max, w_at_zero, w_limit}, eb, el);
    else      chk(nm, {lv, lv_bin, at_max, at_zero, limit}, eb, el);
  endtask

  task automatic add(input logic sz, input logic o, input logic u, input logic d,
                     input int eb, input logic el);
    vec_t v;
    v.sz = sz; v.o = o; v.u = u; v.d = d; v.eb = eb; v.el = el;
    vecs.push_back(v);
  endtask

  initial begin
    // Vector table for the saturating instance, starting from level 0 after reset.
    add(0,0,0,0, 0,0);                                    // idle
    add(0,1,0,0, 1,0);                                    // power on
    add(0,0,0,0, 1,0);
    add(0,1,0,0, 1,0);                                    // second on ignored
    for (int k = 0; k < 12; k++) add(0,0,1,0, 2 + k/4, 0); // hold: edge, +4, +8
    add(0,0,0,0, 4,0);
    add(0,0,1,0, 5,0); add(0,0,0,0, 5,0);
    add(0,0,1,0, 6,0); add(0,0,0,0, 6,0);
    add(0,0,1,0, 7,0); add(0,0,0,0, 7,0);
    for (int k = 0; k < 9; k++) add(0,0,1,0, 8, (k == 4 || k == 8)); // blocked repeats
    add(0,0,0,0, 8,0);
    add(0,0,1,0, 8,1);                                    // blocked edge at max
    add(0,0,0,0, 8,0);
    add(0,0,1,1, 8,0);                                    // both edges: no change
    add(0,0,0,0, 8,0);
    add(0,0,0,1, 7,0); add(0,0,0,0, 7,0);
    add(1,0,1,0, 0,0);                                    // setzero beats up edge
    add(0,0,0,0, 0,0);
    add(0,0,0,1, 0,1);                                    // down at zero blocked
    add(0,0,0,0, 0,0);
    add(0,1,1,0, 1,0);                                    // on beats step at zero
    add(0,0,0,0, 1,0);
    add(0,1,1,0, 2,0);                                    // on ignored above zero
    add(0,0,0,0, 2,0);
    for (int k = 0; k < 6; k++) add(0,0,0,1, (k < 4) ? 1 : 0, 0); // down repeat
    add(0,0,0,0, 0,0);
    add(0,0,1,0, 1,0); add(0,0,1,0, 1,0); add(0,0,1,0, 1,0);
    add(0,0,1,1, 0,0);                                    // down edge while up held, counter cleared
    add(0,0,1,0, 0,0); add(0,0,1,0, 0,0); add(0,0,1,0, 0,0);
    add(0,0,1,0, 1,0);                                    // repeat restarts from cleared counter
    add(0,0,0,0, 1,0);

    reset = 1'b1;
    {setzero, on, up, down}         = 4'b0;
    {w_setzero, w_on, w_up, w_down} = 4'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset_state", {lv, lv_bin, at_max, at_zero, limit}, 0, 0);
    chk("reset_state_wrap", {w_lv, w_lv_bin, w_at_max, w_at_zero, w_limit}, 0, 0);
    #2 reset = 1'b0;

    foreach (vecs[i]) begin
      apply(0, vecs[i].sz, vecs[i].o, vecs[i].u, vecs[i].d, vecs[i].eb, vecs[i].el,
            $sformatf("vec%0d", i));
    end

    // Asynchronous reset while up is held between repeat ticks.
    apply(0, 0,0,1,0, 2,0, "hold_before_rst0");
    apply(0, 0,0,1,0, 2,0, "hold_before_rst1");
    #2 reset = 1'b1;
    #1 chk("rst_async_immediate", {lv, lv_bin, at_max, at_zero, limit}, 0, 0);
    @(posedge clk); #1;
    chk("rst_held_edge", {lv, lv_bin, at_max, at_zero, limit}, 0, 0);
    #1 reset = 1'b0;
    for (int k = 0; k < 5; k++) apply(0, 0,0,1,0, (k < 4) ? 1 : 2, 0, $sformatf("rst_fresh%0d", k));
    apply(0, 0,0,0,0, 2,0, "rst_release");

    // Wrapping instance.
    apply(1, 0,1,0,0, 1,0, "w_on");
    for (int k = 0; k < 7; k++) begin
      apply(1, 0,0,1,0, k + 2, 0, $sformatf("w_up%0d", k));
      apply(1, 0,0,0,0, k + 2, 0, $sformatf("w_idle%0d", k));
    end
    apply(1, 0,0,1,0, 0,1, "w_wrap_up");
    apply(1, 0,0,0,0, 0,0, "w_after_up");
    apply(1, 0,0,0,1, 8,1, "w_wrap_down");
    apply(1, 0,0,0,0, 8,0, "w_after_down");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
